// File: rtl/cpu_checker_plus.sv
// Character-serial trace record checker: decodes register-write and memory-write records.
// Optional misalignment reporting (format_type 11) when CPU_CHECKER_ALIGN_EN is defined.
module cpu_checker_plus #(
   parameter int TIME_DIGITS = 4,
   parameter int GRF_DIGITS  = 4,
   parameter int PC_HEX      = 8,
   parameter int DATA_HEX    = 8,
   parameter int TIME_W      = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            char,
   output logic [1:0]            format_type,
   output logic [TIME_W-1:0]     time_out,
   output logic [4*PC_HEX-1:0]   pc_out,
   output logic [4*PC_HEX-1:0]   dest_out,
   output logic [4*DATA_HEX-1:0] data_out
);

   // state   | meaning
   // S_IDLE  | waiting for '^'
   // S_TIME  | decimal time digits
   // S_PC    | PC hex digits
   // S_COLON | expecting ':'
   // S_SP1   | spaces before '$' or '*'
   // S_GRF   | decimal register number
   // S_ADDR  | memory address hex digits
   // S_SP2   | spaces before '<'
   // S_EQ    | expecting '='
   // S_SP3   | spaces before data
   // S_DATA  | data hex digits
   // S_HASH  | expecting closing '#'

   localparam int ADDR_W = 4*PC_HEX;
   localparam int DATA_W = 4*DATA_HEX;
   localparam int MAX_TG = (TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS;
   localparam int MAX_HX = (PC_HEX > DATA_HEX) ? PC_HEX : DATA_HEX;
   localparam int MAX_D  = (MAX_TG > MAX_HX) ? MAX_TG : MAX_HX;
   localparam int CNT_W  = $clog2(MAX_D + 1);

   localparam logic [CNT_W-1:0] TIME_MAX  = CNT_W'(TIME_DIGITS);
   localparam logic [CNT_W-1:0] GRF_MAX   = CNT_W'(GRF_DIGITS);
   localparam logic [CNT_W-1:0] PC_LAST   = CNT_W'(PC_HEX - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_HEX - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_GRF,
      S_ADDR, S_SP2, S_EQ, S_SP3, S_DATA, S_HASH
   } state_t;

   state_t state, state_nx;

   logic [CNT_W-1:0]  cnt;
   logic [TIME_W-1:0] time_acc;
   logic [TIME_W-1:0] grf_acc;
   logic [ADDR_W-1:0] pc_acc;
   logic [ADDR_W-1:0] addr_acc;
   logic [DATA_W-1:0] data_acc;
   logic              is_mem;
   logic              misalign;

   logic is_dig, is_hex;
   logic [3:0] nib;
   logic cnt_clr, cnt_inc, acc_clr;
   logic ld_time, ld_pc, ld_grf, ld_addr, ld_data;
   logic sel_reg, sel_mem, commit;

   // Letters map to nibble via low bits + 9 for both cases ('a'/'A' low nibble is 1).
   assign is_dig = (char >= "0") && (char <= "9");
   assign is_hex = is_dig || ((char >= "a") && (char <= "f")) || ((char >= "A") && (char <= "F"));
   assign nib    = is_dig ? char[3:0] : char[3:0] + 4'd9;

`ifdef CPU_CHECKER_ALIGN_EN
   assign misalign = (pc_acc[1:0] != 2'b00) || (is_mem && (addr_acc[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = S_IDLE;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      acc_clr  = 1'b0;
      ld_time  = 1'b0;
      ld_pc    = 1'b0;
      ld_grf   = 1'b0;
      ld_addr  = 1'b0;
      ld_data  = 1'b0;
      sel_reg  = 1'b0;
      sel_mem  = 1'b0;
      commit   = 1'b0;
      // '^' restarts a record from any state; anything unexpected falls back to idle.
      if (char == "^") begin
         state_nx = S_TIME;
         acc_clr  = 1'b1;
         cnt_clr  = 1'b1;
      end else begin
         case (state)
            S_TIME: begin
               if (is_dig && cnt != TIME_MAX) begin
                  state_nx = S_TIME;
                  ld_time  = 1'b1;
                  cnt_inc  = 1'b1;
               end else if (char == "@" && cnt != '0) begin
                  state_nx = S_PC;
                  cnt_clr  = 1'b1;
               end
            end
            S_PC: begin
               if (is_hex) begin
                  ld_pc    = 1'b1;
                  cnt_inc  = 1'b1;
                  state_nx = (cnt == PC_LAST) ? S_COLON : S_PC;
               end
            end
            S_COLON: if (char == ":") state_nx = S_SP1;
            S_SP1: begin
               if (char == " ") state_nx = S_SP1;
               else if (char == "$") begin
                  state_nx = S_GRF;
                  cnt_clr  = 1'b1;
                  sel_reg  = 1'b1;
               end else if (char == "*") begin
                  state_nx = S_ADDR;
                  cnt_clr  = 1'b1;
                  sel_mem  = 1'b1;
               end
            end
            S_GRF: begin
               if (is_dig && cnt != GRF_MAX) begin
                  state_nx = S_GRF;
                  ld_grf   = 1'b1;
                  cnt_inc  = 1'b1;
               end else if (cnt != '0 && char == " ") state_nx = S_SP2;
               else if (cnt != '0 && char == "<") state_nx = S_EQ;
            end
            S_ADDR: begin
               if (is_hex) begin
                  ld_addr  = 1'b1;
                  cnt_inc  = 1'b1;
                  state_nx = (cnt == PC_LAST) ? S_SP2 : S_ADDR;
               end
            end
            S_SP2: begin
               if (char == " ") state_nx = S_SP2;
               else if (char == "<") state_nx = S_EQ;
            end
            S_EQ: if (char == "=") state_nx = S_SP3;
            S_SP3: begin
               if (char == " ") state_nx = S_SP3;
               else if (is_hex) begin
                  // first data digit is consumed here, so the counter starts at one
                  ld_data  = 1'b1;
                  cnt_clr  = 1'b1;
                  cnt_inc  = 1'b1;
                  state_nx = (DATA_HEX == 1) ? S_HASH : S_DATA;
               end
            end
            S_DATA: begin
               if (is_hex) begin
                  ld_data  = 1'b1;
                  cnt_inc  = 1'b1;
                  state_nx = (cnt == DATA_LAST) ? S_HASH : S_DATA;
               end
            end
            S_HASH: if (char == "#") commit = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt         <= '0;
         time_acc    <= '0;
         grf_acc     <= '0;
         pc_acc      <= '0;
         addr_acc    <= '0;
         data_acc    <= '0;
         is_mem      <= 1'b0;
         format_type <= 2'b00;
         time_out    <= '0;
         pc_out      <= '0;
         dest_out    <= '0;
         data_out    <= '0;
      end else begin
         format_type <= 2'b00;
         if (cnt_clr)      cnt <= cnt_inc ? CNT_W'(1) : '0;
         else if (cnt_inc) cnt <= cnt + CNT_W'(1);
         if (acc_clr) begin
            time_acc <= '0;
            grf_acc  <= '0;
            pc_acc   <= '0;
            addr_acc <= '0;
            data_acc <= '0;
         end
         if (ld_time) time_acc <= time_acc * TIME_W'(10) + TIME_W'(nib);
         if (ld_grf)  grf_acc  <= grf_acc * TIME_W'(10) + TIME_W'(nib);
         if (ld_pc)   pc_acc   <= {pc_acc[ADDR_W-5:0], nib};
         if (ld_addr) addr_acc <= {addr_acc[ADDR_W-5:0], nib};
         if (ld_data) data_acc <= {data_acc[DATA_W-5:0], nib};
         if (sel_mem)      is_mem <= 1'b1;
         else if (sel_reg) is_mem <= 1'b0;
         if (commit) begin
            format_type <= misalign ? 2'b11 : (is_mem ? 2'b10 : 2'b01);
            time_out    <= time_acc;
            pc_out      <= pc_acc;
            dest_out    <= is_mem ? addr_acc : ADDR_W'(grf_acc);
            data_out    <= data_acc;
         end
      end
   end

endmodule
